// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: state encoding, default widths
// and the absolute branch-target table.
package fetch_pkg;

    localparam int unsigned ADefault    = 12;
    localparam int unsigned LutWDefault = 3;
    localparam int unsigned OffWDefault = 5;
    localparam int unsigned CntWDefault = 16;

    localparam int unsigned LutEntries = 2 ** LutWDefault;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StRun    = 2'd2,
        StHalted = 2'd3
    } fetch_state_e;

    // Absolute branch targets; entry i = 16*i. Edit here when programs change.
    localparam logic [ADefault-1:0] BrLut [LutEntries] = '{
        12'd0,  12'd16, 12'd32, 12'd48,
        12'd64, 12'd80, 12'd96, 12'd112
    };

endpackage

// File: rtl/branch_lut.sv
// Combinational lookup of an absolute branch target from the package table.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int unsigned A     = ADefault,
    parameter int unsigned LUT_W = LutWDefault
) (
    input  logic [LUT_W-1:0] tgt_idx,
    output logic [A-1:0]     target
);

    assign target = A'(BrLut[tgt_idx]);

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencing: start/load handshake, absolute and
// relative branches, halt handling and a saturating retired-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned A     = ADefault,
    parameter int unsigned LUT_W = LutWDefault,
    parameter int unsigned OFF_W = OffWDefault,
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [A-1:0]     StartAddr,
    input  logic             Halt,
    input  logic             BrTaken,
    input  logic             BrRel,
    input  logic [LUT_W-1:0] TgtIdx,
    input  logic [OFF_W-1:0] Offset,
    output logic [A-1:0]     ProgCtr,
    output logic             Done,
    output logic [CNT_W-1:0] RetCount
);

    fetch_state_e     state_q, state_d;
    logic [A-1:0]     pc_q, pc_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [A-1:0]     lut_target;
    logic [A-1:0]     offset_ext;
    logic [CNT_W-1:0] cnt_sat_inc;

    branch_lut #(
        .A     (A),
        .LUT_W (LUT_W)
    ) u_branch_lut (
        .tgt_idx (TgtIdx),
        .target  (lut_target)
    );

    assign offset_ext  = {{(A - OFF_W){Offset[OFF_W-1]}}, Offset};
    assign cnt_sat_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StHalted: begin
                if (Start) begin
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (Start) begin
                    pc_d = StartAddr;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (Start) begin
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = StLoad;
                end else begin
                    // Every non-start RUN cycle retires one instruction, halt included.
                    cnt_d = cnt_sat_inc;
                    if (Halt) begin
                        done_d  = 1'b1;
                        state_d = StHalted;
                    end else if (BrTaken && !BrRel) begin
                        pc_d = lut_target;
                    end else if (BrTaken) begin
                        pc_d = pc_q + offset_ext;
                    end else begin
                        pc_d = pc_q + A'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ProgCtr  = pc_q;
    assign Done     = done_q;
    assign RetCount = cnt_q;

endmodule
